// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / branch hazard controller.
package hazard_pkg;

    localparam int unsigned RegW = 5;
    localparam int unsigned CntW = 4;
    localparam int unsigned StatW = 16;

    localparam logic [RegW-1:0] RegZero = '0;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// The stats counters exist only when HAZARD_CTRL_STATS_EN is defined.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic            idex_mem_read;
    logic [RegW-1:0] idex_rt;
    logic [RegW-1:0] ifid_rs;
    logic [RegW-1:0] ifid_rt;
    logic            branch_taken;
    logic            ext_stall;
    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            busy;
`ifdef HAZARD_CTRL_STATS_EN
    logic [StatW-1:0] stall_count;
    logic [StatW-1:0] flush_count;
`endif

    // Pipeline side: drives hazard sources, receives enables.
    modport master (
        output idex_mem_read, idex_rt, ifid_rs, ifid_rt, branch_taken, ext_stall,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, busy
`ifdef HAZARD_CTRL_STATS_EN
        , input stall_count, flush_count
`endif
    );

    modport slave (
        input  idex_mem_read, idex_rt, ifid_rs, ifid_rt, branch_taken, ext_stall,
        output pc_write, ifid_write, ifid_flush, idex_bubble, busy
`ifdef HAZARD_CTRL_STATS_EN
        , output stall_count, flush_count
`endif
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard comparator: a load into a nonzero register
// that the instruction behind it reads.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic            mem_read_i,
    input  logic [RegW-1:0] idex_rt_i,
    input  logic [RegW-1:0] ifid_rs_i,
    input  logic [RegW-1:0] ifid_rt_i,
    output logic            hazard_o
);

    always_comb begin
        hazard_o = mem_read_i && (idex_rt_i != RegZero)
                   && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, external freeze.
// Optional stall/flush statistics counters under HAZARD_CTRL_STATS_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);

    localparam logic [CntW-1:0] StallLoad = CntW'(STALL_CYCLES - 1);
    localparam logic [CntW-1:0] FlushLoad = CntW'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            hazard;

    hazard_detect u_detect (
        .mem_read_i (bus.idex_mem_read),
        .idex_rt_i  (bus.idex_rt),
        .ifid_rs_i  (bus.ifid_rs),
        .ifid_rt_i  (bus.ifid_rt),
        .hazard_o   (hazard)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        if (rst) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (bus.ext_stall) begin
            // Full freeze; the source holds any branch until released.
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
        end else if (bus.branch_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = StFlush;
                cnt_d   = FlushLoad;
            end else begin
                state_d = StRun;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hazard) begin
                        bus.pc_write    = 1'b0;
                        bus.ifid_write  = 1'b0;
                        bus.idex_bubble = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = StStall;
                            cnt_d   = StallLoad;
                        end
                    end
                end
                StStall: begin
                    bus.pc_write    = 1'b0;
                    bus.ifid_write  = 1'b0;
                    bus.idex_bubble = 1'b1;
                    if (cnt_q <= CntW'(1)) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StFlush: begin
                    bus.ifid_flush = 1'b1;
                    if (cnt_q <= CntW'(1)) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.busy = !rst && (state_q != StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_CTRL_STATS_EN
    logic [StatW-1:0] stall_count_q, flush_count_q;
    logic             stall_inc, flush_inc;

    // Enables are already all-zero under ext_stall, which freezes the counts.
    always_comb begin
        stall_inc = bus.idex_bubble && !bus.ifid_flush;
        flush_inc = bus.ifid_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (stall_inc && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + StatW'(1);
            end
            if (flush_inc && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + StatW'(1);
            end
        end
    end

    always_comb begin
        bus.stall_count = stall_count_q;
        bus.flush_count = flush_count_q;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with three parameterisations driven in lockstep.
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    hazard_ctrl_if bus1 ();
    hazard_ctrl_if bus3 ();
    hazard_ctrl_if bus4 ();

    hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
    hazard_ctrl #(.STALL_CYCLES(4), .FLUSH_CYCLES(1)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Packed view: {pc_write, ifid_write, ifid_flush, idex_bubble, busy}
    logic [4:0] o1, o3, o4;
    assign o1 = {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_bubble, bus1.busy};
    assign o3 = {bus3.pc_write, bus3.ifid_write, bus3.ifid_flush, bus3.idex_bubble, bus3.busy};
    assign o4 = {bus4.pc_write, bus4.ifid_write, bus4.ifid_flush, bus4.idex_bubble, bus4.busy};

    localparam logic [4:0] ORun   = 5'b11000;
    localparam logic [4:0] ORst   = 5'b00110;
    localparam logic [4:0] OHaz   = 5'b00010;
    localparam logic [4:0] OStall = 5'b00011;
    localparam logic [4:0] OBr    = 5'b11110;
    localparam logic [4:0] OBrFl  = 5'b11111;
    localparam logic [4:0] OFlush = 5'b11101;
    localparam logic [4:0] OFrzR  = 5'b00000;
    localparam logic [4:0] OFrzS  = 5'b00001;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic es);
        bus1.idex_mem_read = mr; bus1.idex_rt = irt; bus1.ifid_rs = rs; bus1.ifid_rt = rt;
        bus1.branch_taken = br; bus1.ext_stall = es;
        bus3.idex_mem_read = mr; bus3.idex_rt = irt; bus3.ifid_rs = rs; bus3.ifid_rt = rt;
        bus3.branch_taken = br; bus3.ext_stall = es;
        bus4.idex_mem_read = mr; bus4.idex_rt = irt; bus4.ifid_rs = rs; bus4.ifid_rt = rt;
        bus4.branch_taken = br; bus4.ext_stall = es;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;

        // Reset outputs
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("rst_o1", 32'(o1), 32'(ORst));
        chk("rst_o3", 32'(o3), 32'(ORst));
        chk("rst_o4", 32'(o4), 32'(ORst));
        step();
        rst = 1'b0;

        // Idle RUN
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("idle_o1", 32'(o1), 32'(ORun));
        chk("idle_o4", 32'(o4), 32'(ORun));
        chk("idle_cnt4", 32'(u_dut4.cnt_q), 32'd0);
        step();

        // Load into r0 is never a hazard
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("r0_o1", 32'(o1), 32'(ORun));
        chk("r0_o3", 32'(o3), 32'(ORun));
        step();

        // Load r5, consumer reads r5 via rs
        drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
        chk("lu_c1_o1", 32'(o1), 32'(OHaz));
        chk("lu_c1_o3", 32'(o3), 32'(OHaz));
        chk("lu_c1_o4", 32'(o4), 32'(OHaz));
        step();
        drive(1'b0, 5'd0, 5'd5, 5'd9, 1'b0, 1'b0);
        chk("lu_c2_o1", 32'(o1), 32'(ORun));
        chk("lu_c2_o3", 32'(o3), 32'(OStall));
        chk("lu_c2_o4", 32'(o4), 32'(OStall));
        step();
        chk("lu_c3_o3", 32'(o3), 32'(OStall));
        chk("lu_c3_o4", 32'(o4), 32'(OStall));
        step();
        chk("lu_c4_o3", 32'(o3), 32'(ORun));
        chk("lu_c4_o4", 32'(o4), 32'(OStall));
        step();
        chk("lu_c5_o4", 32'(o4), 32'(ORun));
        step();

        // Branch coincident with hazard: branch wins, then a second branch in FLUSH
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        chk("br_c1_o1", 32'(o1), 32'(OBr));
        chk("br_c1_o3", 32'(o3), 32'(OBr));
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("br_c2_o1", 32'(o1), 32'(ORun));
        chk("br_c2_o3", 32'(o3), 32'(OFlush));
        step();
        chk("br_c3_o3", 32'(o3), 32'(ORun));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        chk("rebr_c2_o3", 32'(o3), 32'(OBrFl));
        chk("rebr_cnt3", 32'(u_dut3.cnt_q), 32'd1);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("rebr_c3_o3", 32'(o3), 32'(OFlush));
        step();
        chk("rebr_c4_o3", 32'(o3), 32'(ORun));

        // ext_stall beats branch and hazard, and freezes state
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
        chk("frz_o1", 32'(o1), 32'(OFrzR));
        chk("frz_o3", 32'(o3), 32'(OFrzR));
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("frz_after_o3", 32'(o3), 32'(ORun));
        step();

        // ext_stall for 3 cycles mid-STALL, hazard via ifid_rt
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
        chk("es_c1_o4", 32'(o4), 32'(OHaz));
        step();
        drive(1'b0, 5'd0, 5'd3, 5'd7, 1'b0, 1'b0);
        chk("es_c2_o4", 32'(o4), 32'(OStall));
        chk("es_c2_cnt4", 32'(u_dut4.cnt_q), 32'd3);
        step();
        drive(1'b0, 5'd0, 5'd3, 5'd7, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("es_frz_o4", 32'(o4), 32'(OFrzS));
            chk("es_frz_cnt4", 32'(u_dut4.cnt_q), 32'd2);
            step();
        end
        drive(1'b0, 5'd0, 5'd3, 5'd7, 1'b0, 1'b0);
        chk("es_res1_o4", 32'(o4), 32'(OStall));
        chk("es_res1_cnt4", 32'(u_dut4.cnt_q), 32'd2);
        step();
        chk("es_res2_o4", 32'(o4), 32'(OStall));
        chk("es_res2_cnt4", 32'(u_dut4.cnt_q), 32'd1);
        step();
        chk("es_done_o4", 32'(o4), 32'(ORun));
        chk("es_done_cnt4", 32'(u_dut4.cnt_q), 32'd0);

        // Reset in the 2nd stall cycle
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        chk("rs_c1_o4", 32'(o4), 32'(OHaz));
        step();
        drive(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rs_c2_o4", 32'(o4), 32'(ORst));
        step();
        rst = 1'b0;
        #1;
        chk("rs_after_o4", 32'(o4), 32'(ORun));
        chk("rs_after_cnt4", 32'(u_dut4.cnt_q), 32'd0);
`ifdef HAZARD_CTRL_STATS_EN
        chk("rs_stall_cnt4", 32'(bus4.stall_count), 32'd0);
        chk("rs_flush_cnt4", 32'(bus4.flush_count), 32'd0);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("st_stall_cnt1", 32'(bus1.stall_count), 32'd1);
        chk("st_flush_cnt1", 32'(bus1.flush_count), 32'd1);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
